// File: rtl/uart_rx_ovs_if.sv
// Receive-word handshake bundle between the UART receiver and its consumer.
// Latency: none (wires only).
// Backpressure: consumer holds rready low to keep the current word in place.
interface uart_rx_ovs_if #(
    parameter int DW = 9
);
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rready;
    logic          parity_err;
    logic          frame_err;
    logic          break_det;

    modport master (
        output rdata, rvalid, parity_err, frame_err, break_det,
        input  rready
    );

    modport slave (
        input  rdata, rvalid, parity_err, frame_err, break_det,
        output rready
    );
endinterface

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: majority-voted bits, parity, 1/2 stops, break, idle timeout.
// Latency: word valid at the mid-sample (tick OVS/2+1) of the last stop bit.
// Backpressure: one-entry holding register; a frame completing while it is full and not drained is dropped (overrun).
module uart_rx_ovs #(
    parameter int MAX_DW = 9,
    parameter int OVS    = 8,
    parameter int PR_W   = 16,
    parameter int TO_W   = 6
) (
    input  logic            PCLK,
    input  logic            PRESETn,
    input  logic            en,
    input  logic [PR_W-1:0] prescaler,
    input  logic [3:0]      data_size,
    input  logic [2:0]      parity,
    input  logic            stop2,
    input  logic [TO_W-1:0] timeout_bits,
    input  logic            rx,
    uart_rx_ovs_if.master   rbus,
    output logic            overrun,
    output logic            timeout
);
    localparam int CW  = $clog2(OVS);
    localparam int MID = OVS / 2 + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t            state, state_nxt;
    logic [PR_W-1:0]   pr_cnt;
    logic              tick;
    logic              rx_s1, rx_s2, rx_prev;
    logic              fall;
    logic [CW-1:0]     ovs_cnt;
    logic              at_mid, at_end;
    logic              s0, s1, maj;
    logic [3:0]        bit_idx;
    logic [3:0]        dsz;
    logic              par_en, par_exp;
    logic [MAX_DW-1:0] shreg;
    logic              pe_pend, fe_pend, brk_pend;
    logic              done, fe_fin, brk_fin;
    logic [MAX_DW-1:0] rdata_q;
    logic              rvalid_q, pe_q, fe_q, brk_q;
    logic              armed;
    logic [CW-1:0]     to_sub;
    logic [TO_W-1:0]   to_bits;

    // Out-of-range frame widths fall back to the widest frame.
    assign dsz    = (data_size < 4'd5 || data_size > 4'(MAX_DW)) ? 4'(MAX_DW) : data_size;
    assign par_en = (parity == 3'b001) || (parity == 3'b010) ||
                    (parity == 3'b100) || (parity == 3'b101);

    // Expected parity bit; shreg upper bits are zero so a full-width XOR is safe.
    always_comb begin
        par_exp = 1'b0;
        case (parity)
            3'b001:  par_exp = ~(^shreg);
            3'b010:  par_exp = ^shreg;
            3'b101:  par_exp = 1'b1;
            default: par_exp = 1'b0;
        endcase
    end

    // Prescaler: one sample tick per prescaler+1 clocks, parked while disabled.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                pr_cnt <= '0;
        else if (!en)                pr_cnt <= '0;
        else if (pr_cnt == prescaler) pr_cnt <= '0;
        else                         pr_cnt <= pr_cnt + 1'b1;
    end
    assign tick = en && (pr_cnt == prescaler);

    // Two-flop synchroniser plus a delayed copy for falling-edge detection; idles high.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end
    assign fall   = rx_prev & ~rx_s2;
    assign at_mid = tick && (ovs_cnt == CW'(MID));
    assign at_end = tick && (ovs_cnt == CW'(OVS - 1));
    assign maj    = (s0 & s1) | (s0 & rx_s2) | (s1 & rx_s2);

    // Flags as they will be latched when the last stop bit resolves.
    assign fe_fin  = fe_pend | ~maj;
    assign brk_fin = (state == STOP1) ? (brk_pend & ~maj) : brk_pend;

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic and frame-completion strobe.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:   if (fall) state_nxt = START;
                START: begin
                    if (at_mid && maj) state_nxt = IDLE;
                    else if (at_end)   state_nxt = DATA;
                end
                DATA:   if (at_end && bit_idx == dsz - 4'd1)
                            state_nxt = par_en ? PARITY : STOP1;
                PARITY: if (at_end) state_nxt = STOP1;
                STOP1: begin
                    if (at_mid && !stop2) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end else if (at_end && stop2) begin
                        state_nxt = STOP2;
                    end
                end
                STOP2: begin
                    if (at_mid) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Bit timing, voting samples and frame assembly.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ovs_cnt  <= '0;
            s0       <= 1'b1;
            s1       <= 1'b1;
            bit_idx  <= '0;
            shreg    <= '0;
            pe_pend  <= 1'b0;
            fe_pend  <= 1'b0;
            brk_pend <= 1'b0;
        end else if (!en || state == IDLE) begin
            ovs_cnt <= '0;
            if (en && fall) begin
                bit_idx  <= '0;
                shreg    <= '0;
                pe_pend  <= 1'b0;
                fe_pend  <= 1'b0;
                brk_pend <= 1'b1;
            end
        end else if (tick) begin
            if (ovs_cnt == CW'(OVS - 1) || state_nxt == IDLE) ovs_cnt <= '0;
            else                                               ovs_cnt <= ovs_cnt + 1'b1;
            if (ovs_cnt == CW'(MID - 2)) s0 <= rx_s2;
            if (ovs_cnt == CW'(MID - 1)) s1 <= rx_s2;
            if (at_mid) begin
                case (state)
                    DATA: begin
                        shreg[bit_idx] <= maj;
                        if (maj) brk_pend <= 1'b0;
                    end
                    PARITY: begin
                        pe_pend <= (maj != par_exp);
                        if (maj) brk_pend <= 1'b0;
                    end
                    STOP1: begin
                        fe_pend  <= fe_pend | ~maj;
                        brk_pend <= brk_pend & ~maj;
                    end
                    default: ;
                endcase
            end
            if (at_end && state == DATA) bit_idx <= bit_idx + 4'd1;
        end
    end

    // Holding register: load on completion unless full and undrained, then flag overrun.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
            brk_q    <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!rvalid_q || rbus.rready) begin
                    rdata_q  <= shreg;
                    rvalid_q <= 1'b1;
                    pe_q     <= pe_pend;
                    fe_q     <= fe_fin;
                    brk_q    <= brk_fin;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rvalid_q && rbus.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign rbus.rdata      = rdata_q;
    assign rbus.rvalid     = rvalid_q;
    assign rbus.parity_err = pe_q;
    assign rbus.frame_err  = fe_q;
    assign rbus.break_det  = brk_q;

    // Idle timeout: count whole bit times after a frame, fire once, re-arm on the next frame.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            armed   <= 1'b0;
            to_sub  <= '0;
            to_bits <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (done) begin
                armed   <= 1'b1;
                to_sub  <= '0;
                to_bits <= '0;
            end else if (fall) begin
                to_sub  <= '0;
                to_bits <= '0;
            end else if (armed && state == IDLE && tick && timeout_bits != '0) begin
                if (to_sub == CW'(OVS - 1)) begin
                    to_sub <= '0;
                    if (to_bits + TO_W'(1) == timeout_bits) begin
                        timeout <= 1'b1;
                        armed   <= 1'b0;
                        to_bits <= '0;
                    end else begin
                        to_bits <= to_bits + TO_W'(1);
                    end
                end else begin
                    to_sub <= to_sub + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: 10 MHz clock, prescaler 10, OVS 8 (88 clocks per bit).
// Inputs are driven on the falling clock edge; outputs are observed away from the rising edge.
// Every expected value below is a hand-computed constant.
module tb_uart_rx_ovs;
    localparam int BT = 88;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        en = 1'b0;
    logic [15:0] prescaler = 16'd10;
    logic [3:0]  data_size = 4'd8;
    logic [2:0]  parity = 3'b000;
    logic        stop2 = 1'b0;
    logic [5:0]  timeout_bits = 6'd0;
    logic        rx = 1'b1;
    logic        overrun, timeout;

    uart_rx_ovs_if #(.DW(9)) rbus ();

    uart_rx_ovs #(.MAX_DW(9), .OVS(8), .PR_W(16), .TO_W(6)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .en(en), .prescaler(prescaler),
        .data_size(data_size), .parity(parity), .stop2(stop2),
        .timeout_bits(timeout_bits), .rx(rx), .rbus(rbus.master),
        .overrun(overrun), .timeout(timeout)
    );

    always #50 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    // Event monitor, sampled shortly after each rising edge.
    int   rise_cnt = 0, rise_cyc = 0;
    int   ov_cnt = 0, ov_cyc = 0;
    int   to_cnt = 0, to_cyc = 0;
    logic rv_d = 1'b0;
    always @(posedge PCLK) begin
        #2;
        if (rbus.rvalid && !rv_d) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        rv_d = rbus.rvalid;
        if (overrun) begin
            ov_cnt++;
            ov_cyc = cyc;
        end
        if (timeout) begin
            to_cnt++;
            to_cyc = cyc;
        end
    end

    int n_checks = 0, n_fail = 0;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    int frame_start = 0;

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BT) @(negedge PCLK);
    endtask

    task automatic send_frame(input logic [8:0] d, input int nd, input bit has_par,
                              input logic pbit, input int nstop);
        frame_start = cyc;
        send_bit(1'b0);
        for (int i = 0; i < nd; i++) send_bit(d[i]);
        if (has_par) send_bit(pbit);
        for (int i = 0; i < nstop; i++) send_bit(1'b1);
    endtask

    task automatic pulse_rdy();
        rbus.rready = 1'b1;
        @(negedge PCLK);
        rbus.rready = 1'b0;
        @(negedge PCLK);
    endtask

    task automatic check_word(input string tag, input logic [8:0] d, input logic pe,
                              input logic fe, input logic brk);
        check({tag, "_rvalid"}, 32'(rbus.rvalid), 32'd1);
        check({tag, "_rdata"}, 32'(rbus.rdata), 32'(d));
        check({tag, "_perr"}, 32'(rbus.parity_err), 32'(pe));
        check({tag, "_ferr"}, 32'(rbus.frame_err), 32'(fe));
        check({tag, "_brk"}, 32'(rbus.break_det), 32'(brk));
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    int lat, r0, o0, t0, ref_start, ov_lat;

    initial begin
        rbus.rready = 1'b0;
        repeat (3) @(negedge PCLK);
        check("rst_rvalid", 32'(rbus.rvalid), 32'd0);
        check("rst_rdata", 32'(rbus.rdata), 32'd0);
        check("rst_flags", {29'd0, rbus.parity_err, rbus.frame_err, rbus.break_det}, 32'd0);
        check("rst_pulses", {30'd0, overrun, timeout}, 32'd0);
        PRESETn = 1'b1;
        en = 1'b1;
        repeat (20) @(negedge PCLK);

        // 8N1 0xA5: word arrives about 9.75 bit times after the start edge.
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1);
        lat = rise_cyc - frame_start;
        check("a5_latency_window", 32'(lat >= 845 && lat <= 865), 32'd1);
        check_word("a5", 9'h0A5, 1'b0, 1'b0, 1'b0);
        pulse_rdy();
        check("a5_drain_rvalid", 32'(rbus.rvalid), 32'd0);
        check("a5_drain_hold", 32'(rbus.rdata), 32'h0A5);

        // 9 bits, even parity, two stops: 0x1C3 has five ones so parity bit is 1.
        data_size = 4'd9; parity = 3'b010; stop2 = 1'b1;
        send_frame(9'h1C3, 9, 1'b1, 1'b1, 2);
        check_word("p_ok", 9'h1C3, 1'b0, 1'b0, 1'b0);
        pulse_rdy();
        send_frame(9'h1C3, 9, 1'b1, 1'b0, 2);
        check_word("p_bad", 9'h1C3, 1'b1, 1'b0, 1'b0);
        pulse_rdy();
        data_size = 4'd8; parity = 3'b000; stop2 = 1'b0;
        repeat (20) @(negedge PCLK);

        // Glitch shorter than the start-bit midpoint is rejected, next frame is clean.
        r0 = rise_cnt;
        rx = 1'b0;
        repeat (30) @(negedge PCLK);
        rx = 1'b1;
        repeat (300) @(negedge PCLK);
        check("glitch_no_word", 32'(rise_cnt - r0), 32'd0);
        check("glitch_rvalid", 32'(rbus.rvalid), 32'd0);
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1);
        check("after_glitch_count", 32'(rise_cnt - r0), 32'd1);
        check_word("after_glitch", 9'h03C, 1'b0, 1'b0, 1'b0);
        pulse_rdy();

        // Break: line low for 12 bit times yields one zero word with break and frame error.
        r0 = rise_cnt;
        rx = 1'b0;
        repeat (12 * BT) @(negedge PCLK);
        rx = 1'b1;
        repeat (3 * BT) @(negedge PCLK);
        check("break_count", 32'(rise_cnt - r0), 32'd1);
        check_word("break", 9'h000, 1'b0, 1'b1, 1'b1);
        pulse_rdy();
        repeat (2 * BT) @(negedge PCLK);
        check("break_no_second", 32'(rise_cnt - r0), 32'd1);

        // Overrun: second frame completes while the first is still held.
        r0 = rise_cnt; o0 = ov_cnt;
        send_frame(9'h011, 8, 1'b0, 1'b0, 1);
        send_frame(9'h022, 8, 1'b0, 1'b0, 1);
        ref_start = frame_start;
        ov_lat = ov_cyc - frame_start;
        check("ovr_pulses", 32'(ov_cnt - o0), 32'd1);
        check("ovr_one_rise", 32'(rise_cnt - r0), 32'd1);
        check_word("ovr_kept", 9'h011, 1'b0, 1'b0, 1'b0);

        // Same prescaler phase, rready raised only on the completion cycle: word replaced, no overrun.
        o0 = ov_cnt;
        repeat (BT) @(negedge PCLK);
        for (int k = 0; k < 11 && ((cyc - ref_start) % 11) != 0; k++) @(negedge PCLK);
        check("ovr2_nothing_yet", 32'(rbus.rdata), 32'h011);
        fork
            send_frame(9'h022, 8, 1'b0, 1'b0, 1);
            begin
                repeat (ov_lat - 1) @(negedge PCLK);
                rbus.rready = 1'b1;
                @(negedge PCLK);
                rbus.rready = 1'b0;
            end
        join
        check("ovr2_no_pulse", 32'(ov_cnt - o0), 32'd0);
        check_word("ovr2_replaced", 9'h022, 1'b0, 1'b0, 1'b0);
        pulse_rdy();

        // Idle timeout fires once, exactly 4 bit times (352 clocks) after completion.
        timeout_bits = 6'd4;
        t0 = to_cnt;
        send_frame(9'h055, 8, 1'b0, 1'b0, 1);
        repeat (10 * BT) @(negedge PCLK);
        check("to_once", 32'(to_cnt - t0), 32'd1);
        check("to_delay", 32'(to_cyc - rise_cyc), 32'd352);
        check_word("to_word", 9'h055, 1'b0, 1'b0, 1'b0);

        // Disable during bit 3: partial frame dropped, held word and handshake survive.
        r0 = rise_cnt;
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        send_bit(1'b1);
        repeat (200) @(negedge PCLK);
        check("dis_no_word", 32'(rise_cnt - r0), 32'd0);
        check_word("dis_hold", 9'h055, 1'b0, 1'b0, 1'b0);
        pulse_rdy();
        check("dis_drain", 32'(rbus.rvalid), 32'd0);
        en = 1'b1;
        repeat (20) @(negedge PCLK);
        send_frame(9'h096, 8, 1'b0, 1'b0, 1);
        check("reen_count", 32'(rise_cnt - r0), 32'd1);
        check_word("reen", 9'h096, 1'b0, 1'b0, 1'b0);
        pulse_rdy();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
